wb_uart_rx_fifo: RTL

//  UART receiver with a 16x-oversampled front end, an RX FIFO and a Wishbone classic slave register port.

---
 rtl/wb_uart_rx_fifo.sv | 275 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/wb_uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : wb_uart_rx_fifo
// Purpose  : UART receiver (16x oversampled), 2**FIFO_AW x 8 RX FIFO and a
//            Wishbone classic slave register port. The CPU polls STATUS or
//            takes irq_o, then reads bytes from RXDATA.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports    : clock            wb clock, rising edge
//            reset            synchronous, active-high
//            wb_adr_i[3:0]    byte address, [3:2] selects register
//            wb_dat_i[31:0]   write data
//            wb_dat_o[31:0]   read data (held between acks)
//            wb_sel_i[3:0]    byte selects (full-word access only, ignored)
//            wb_we_i          write enable
//            wb_cyc_i         bus cycle
//            wb_stb_i         strobe
//            wb_ack_o         registered single-cycle acknowledge
//            uart_rx          async serial input, idles high
//            irq_o            high while FIFO not empty (registered)
// Registers: 0x0 RXDATA (R, pops)  0x4 STATUS (R, W1C [4:2])  0x8/0xC zero
// Config   : `UART_RX_PARITY_EN adds an even-parity bit after the data bits
//            and makes STATUS[4] (PE) live. Undefined: plain 8N1.
// ============================================================================
module wb_uart_rx_fifo #(
  parameter int CLK_FREQ_HZ = 24000000,
  parameter int BAUD        = 115200,
  parameter int FIFO_AW     = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [3:0]  wb_adr_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_we_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  output logic        wb_ack_o,
  input  logic        uart_rx,
  output logic        irq_o
);

  localparam int OS_DIV = (CLK_FREQ_HZ + BAUD * 8) / (BAUD * 16);
  localparam int DIV_W  = (OS_DIV > 1) ? $clog2(OS_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(OS_DIV - 1);
  localparam int DEPTH  = 2 ** FIFO_AW;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
    S_PARITY = 3'd3,
`endif
    S_STOP   = 3'd4,
    S_BREAK  = 3'd5
  } state_t;

  state_t             state_q, state_d;
  logic               rx_s1_q, rx_s1_d, rx_s2_q, rx_s2_d, rx_prev_q, rx_prev_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [3:0]         sc_q, sc_d;
  logic [2:0]         bit_q, bit_d;
  logic [7:0]         shreg_q, shreg_d;
  logic               perr_q, perr_d;
  logic [FIFO_AW:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [7:0]         mem_q [DEPTH];
  logic               ovr_q, ovr_d, fe_q, fe_d, pe_q, pe_d;
  logic               ack_q, ack_d, irq_q, irq_d;
  logic [31:0]        dat_q, dat_d;

  logic               w_tick, w_push, w_fe_set, w_pe_set;
  logic               w_empty, w_full, w_req, w_pop, w_push_ok, w_ovr_set;
  logic [FIFO_AW:0]   w_count;
  logic [1:0]         w_reg_sel;
  logic [2:0]         w_clr;
  logic [31:0]        w_status;
  logic               w_unused;

  assign w_unused = ^{wb_sel_i, wb_adr_i[1:0], wb_dat_i};

  // --------------------------------------------------------------------------
  // Receive front end and frame FSM
  // --------------------------------------------------------------------------
  always_comb begin
    rx_s1_d   = uart_rx;
    rx_s2_d   = rx_s1_q;
    rx_prev_d = rx_s2_q;
    w_tick    = (div_q == DIV_MAX);
    div_d     = w_tick ? '0 : div_q + 1'b1;
    state_d   = state_q;
    sc_d      = sc_q;
    bit_d     = bit_q;
    shreg_d   = shreg_q;
    perr_d    = perr_q;
    w_push    = 1'b0;
    w_fe_set  = 1'b0;
    w_pe_set  = 1'b0;
    case (state_q)
      S_IDLE: begin
        // Falling edge on the synchronised line; realign the tick divider so
        // sample points land mid-bit relative to this edge.
        if (rx_prev_q && !rx_s2_q) begin
          state_d = S_START;
          sc_d    = 4'd0;
          div_d   = '0;
        end
      end
      S_START: begin
        if (w_tick) begin
          if (sc_q == 4'd7) begin
            sc_d = 4'd0;
            if (!rx_s2_q) begin
              state_d = S_DATA;
              bit_d   = 3'd0;
              perr_d  = 1'b0;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            sc_d = sc_q + 4'd1;
          end
        end
      end
      S_DATA: begin
        // sc wraps 15 -> 0 naturally, so every sample is 16 ticks apart.
        if (w_tick) begin
          sc_d = sc_q + 4'd1;
          if (sc_q == 4'd15) begin
            shreg_d = {rx_s2_q, shreg_q[7:1]};
            bit_d   = bit_q + 3'd1;
            if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state_d = S_PARITY;
`else
              state_d = S_STOP;
`endif
            end
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (w_tick) begin
          sc_d = sc_q + 4'd1;
          if (sc_q == 4'd15) begin
            if (rx_s2_q != ^shreg_q) begin
              w_pe_set = 1'b1;
              perr_d   = 1'b1;
            end
            state_d = S_STOP;
          end
        end
      end
`endif
      S_STOP: begin
        if (w_tick) begin
          sc_d = sc_q + 4'd1;
          if (sc_q == 4'd15) begin
            if (rx_s2_q) begin
              w_push  = !perr_q;
              state_d = S_IDLE;
            end else begin
              w_fe_set = 1'b1;
              state_d  = S_BREAK;
            end
          end
        end
      end
      S_BREAK: begin
        if (rx_s2_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // FIFO, flags and Wishbone register port
  // --------------------------------------------------------------------------
  always_comb begin
    w_empty   = (wr_ptr_q == rd_ptr_q);
    w_full    = (wr_ptr_q[FIFO_AW] != rd_ptr_q[FIFO_AW]) &&
                (wr_ptr_q[FIFO_AW-1:0] == rd_ptr_q[FIFO_AW-1:0]);
    w_count   = wr_ptr_q - rd_ptr_q;
    w_req     = wb_cyc_i && wb_stb_i && !ack_q;
    w_reg_sel = wb_adr_i[3:2];
    w_pop     = w_req && !wb_we_i && (w_reg_sel == 2'd0) && !w_empty;
    // A simultaneous pop frees the slot, so a push into a full FIFO succeeds.
    w_push_ok = w_push && (!w_full || w_pop);
    w_ovr_set = w_push && w_full && !w_pop;
    wr_ptr_d  = wr_ptr_q + (FIFO_AW + 1)'(w_push_ok);
    rd_ptr_d  = rd_ptr_q + (FIFO_AW + 1)'(w_pop);
    w_clr     = (w_req && wb_we_i && (w_reg_sel == 2'd1)) ? wb_dat_i[4:2] : 3'b000;
    // Set wins over a same-cycle clear.
    ovr_d     = (ovr_q & ~w_clr[0]) | w_ovr_set;
    fe_d      = (fe_q & ~w_clr[1]) | w_fe_set;
`ifdef UART_RX_PARITY_EN
    pe_d      = (pe_q & ~w_clr[2]) | w_pe_set;
`else
    pe_d      = 1'b0;
`endif
    w_status                 = '0;
    w_status[0]              = !w_empty;
    w_status[1]              = w_full;
    w_status[2]              = ovr_q;
    w_status[3]              = fe_q;
    w_status[4]              = pe_q;
    w_status[8 +: FIFO_AW+1] = w_count;
    ack_d = w_req;
    dat_d = dat_q;
    if (w_req) begin
      dat_d = 32'd0;
      if (!wb_we_i) begin
        case (w_reg_sel)
          2'd0:    dat_d = w_empty ? 32'd0 : {24'd0, mem_q[rd_ptr_q[FIFO_AW-1:0]]};
          2'd1:    dat_d = w_status;
          default: dat_d = 32'd0;
        endcase
      end
    end
    irq_d = !w_empty;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_IDLE;
      rx_s1_q   <= 1'b1;
      rx_s2_q   <= 1'b1;
      rx_prev_q <= 1'b1;
      div_q     <= '0;
      sc_q      <= 4'd0;
      bit_q     <= 3'd0;
      shreg_q   <= 8'd0;
      perr_q    <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      ovr_q     <= 1'b0;
      fe_q      <= 1'b0;
      pe_q      <= 1'b0;
      ack_q     <= 1'b0;
      dat_q     <= 32'd0;
      irq_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      rx_s1_q   <= rx_s1_d;
      rx_s2_q   <= rx_s2_d;
      rx_prev_q <= rx_prev_d;
      div_q     <= div_d;
      sc_q      <= sc_d;
      bit_q     <= bit_d;
      shreg_q   <= shreg_d;
      perr_q    <= perr_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      ovr_q     <= ovr_d;
      fe_q      <= fe_d;
      pe_q      <= pe_d;
      ack_q     <= ack_d;
      dat_q     <= dat_d;
      irq_q     <= irq_d;
    end
  end

  // Storage has no reset; pointers define validity.
  always_ff @(posedge clock) begin
    if (!reset && w_push_ok) mem_q[wr_ptr_q[FIFO_AW-1:0]] <= shreg_q;
  end

  assign wb_ack_o = ack_q;
  assign wb_dat_o = dat_q;
  assign irq_o    = irq_q;

endmodule
`default_nettype wire
